alu_bank_responder: RTL and testbench
=====================================

// Module: alu_bank_responder
// PURPOSE
//  Responder side of the banked ALU command/response interface. It serves
//  N_BANKS independent lanes. Each lane accepts one {command, data1, data2}
//  request and returns one {response, data} result after a fixed
//  per-command latency. It sits behind the initiators/test driver that issue
//  ADD/MULTIPLY/AND requests and check the results on their scoreboard.
// PARAMETERS
//  N_BANKS  4  number of independent lanes
//  ADD_LAT  3  cycles from acceptance to ADD response (1..15)
//  AND_LAT  3  cycles from acceptance to AND response (1..15)
//  MUL_LAT  5  cycles from acceptance to MULTIPLY response (1..15)
// PORTS
//  clock          input   1                 rising-edge clock
//  reset          input   1                 synchronous, active-low reset
//  input_packet   input   N_BANKS x 66      input_packet_t {command[1:0], data1[31:0], data2[31:0]}
//  output_packet  output  N_BANKS x 34      output_packet_t {response[1:0], data[31:0]}
//  busy           output  N_BANKS           lane n is holding an accepted operation
// BEHAVIOUR
//  - Encodings:
//    - command: NOP=0, ADD=1, MULTIPLY=2, AND=3.
//    - response: NO_RESPONSE=0, SUCCESS=1, OVERFLOW=2. Code 3 is reserved and never driven.
//  - Reset (reset==0 at posedge): all lanes go to IDLE and counters clear.
//    - busy=0, response=NO_RESPONSE, data=0.
//    - Reset mid-operation aborts the operation; no response is ever issued for it.
//  - Per-lane FSM: IDLE -> BUSY -> RESP -> IDLE.
//    - IDLE: at posedge, if command!=NOP, capture command/data1/data2,
//      load the latency counter with LAT-1, set busy=1 and go to BUSY.
//      A NOP keeps the lane in IDLE.
//    - BUSY: decrement the counter each cycle. At zero, drive response and
//      data, clear busy and go to RESP.
//    - RESP: response is valid for exactly one cycle, then NO_RESPONSE.
//      Go to IDLE.
//  - Latency: command sampled at edge k gives response visible after edge
//    k+LAT, where LAT is ADD_LAT, AND_LAT or MUL_LAT.
//  - Re-issue rule: a new command can be accepted at the edge after RESP.
//    An initiator that keeps a non-NOP command held gets a re-issue, so
//    initiators drive NOP once a request is done.
//  - Input changes while BUSY/RESP are ignored. There is no queueing and no
//    back-pressure beyond busy.
//  - Arithmetic (unsigned, operands as captured):
//    - ADD: 33-bit sum. data=sum[31:0]; OVERFLOW if sum[32], else SUCCESS.
//    - MULTIPLY: 64-bit product. data=prod[31:0]; OVERFLOW if prod[63:32]!=0, else SUCCESS.
//    - AND: data=data1&data2; always SUCCESS.
//  - data holds the last result while response==NO_RESPONSE; only reset clears it.
//  - Lanes are fully independent. Simultaneous accepts and completions on
//    any combination of lanes are legal and do not interact.
// CONFIGURATION
//  ALU_PERF_CNT_EN
//    - Defined: adds output ports op_count [N_BANKS x 16] and ovf_count
//      [N_BANKS x 16].
//    - op_count increments on each response cycle. ovf_count increments on
//      each OVERFLOW response.
//    - Both counters saturate at 16'hFFFF and clear on reset.
//    - Undefined: these ports and counters do not exist. All other
//      behaviour is identical.
// TESTING
//  1. Hold reset low 2 cycles, then release -> every lane shows
//     data=32'h0, response=NO_RESPONSE, busy=0.
//  2. Lane0 ADD 32'hFFFF_FFFF + 32'h1 for one cycle -> exactly 3 cycles
//     later: OVERFLOW, data=32'h0, for one cycle. Lane0 ADD 2+3 ->
//     SUCCESS, data=5.
//  3. Lane1 MULTIPLY 32'h0001_0000 * 32'h0001_0000 -> after 5 cycles:
//     OVERFLOW, data=0. Lane1 MULTIPLY 3*5 -> SUCCESS, data=15.
//  4. Issue simultaneously:
//     - lane2 AND F0F0_F0F0 & FF00_FF00
//     - lane3 MUL 7*6
//     -> lane2 SUCCESS F000_F000 at +3; lane3 SUCCESS 42 at +5; other
//        lanes stay NO_RESPONSE.
//  5. Lane0 MUL 3*5, then ADD 1+1 on the next cycle while busy -> single
//     response SUCCESS, data=15. The ADD is ignored.
//  6. Lane0 MUL accepted, reset low at +2 -> busy=0, data=0; no response
//     within 10 cycles with command=NOP.
//     With ALU_PERF_CNT_EN, after scenarios 2-3: op_count[0]=2,
//     ovf_count[0]=1, op_count[1]=2, ovf_count[1]=1.

Source files
------------

// File: rtl/alu_bank_responder.sv
// -----------------------------------------------------------------------------
// alu_bank_responder
//
// Responder side of the banked ALU command/response interface. N_BANKS lanes
// run independently. Each lane accepts one {command, data1, data2} request
// while idle, computes ADD / MULTIPLY / AND on the captured operands, and
// returns {response, data} after a fixed per-command latency. The response is
// valid for exactly one cycle. The data field holds the last result until the
// next reset.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-low reset
//   input_packet   per lane {command[1:0], data1[31:0], data2[31:0]}
//   output_packet  per lane {response[1:0], data[31:0]}
//   busy           per lane: an accepted operation is in flight
//   op_count       (ALU_PERF_CNT_EN only) per lane response count, saturating
//   ovf_count      (ALU_PERF_CNT_EN only) per lane OVERFLOW count, saturating
//
// Configuration macro: ALU_PERF_CNT_EN adds the two per-lane 16-bit counters.
//
// Encodings
//   command : NOP=0, ADD=1, MULTIPLY=2, AND=3
//   response: NO_RESPONSE=0, SUCCESS=1, OVERFLOW=2 (3 is never driven)
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module alu_bank_responder #(
    parameter int N_BANKS = 4,
    parameter int ADD_LAT = 3,   // 1..15
    parameter int AND_LAT = 3,   // 1..15
    parameter int MUL_LAT = 5    // 1..15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_BANKS-1:0][65:0]  input_packet,
    output logic [N_BANKS-1:0][33:0]  output_packet,
    output logic [N_BANKS-1:0]        busy
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [N_BANKS-1:0][15:0]  op_count,
    output logic [N_BANKS-1:0][15:0]  ovf_count
`endif
);

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_ADD = 2'd1,
        CMD_MUL = 2'd2,
        CMD_AND = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_NONE     = 2'd0,
        RSP_SUCCESS  = 2'd1,
        RSP_OVERFLOW = 2'd2
    } rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    // The counter is loaded with LAT-1 so that a command sampled at edge k
    // produces its response at edge k+LAT (the zero check takes one edge).
    function automatic logic [3:0] load_value(input cmd_e cmd);
        case (cmd)
            CMD_ADD: load_value = 4'(ADD_LAT - 1);
            CMD_MUL: load_value = 4'(MUL_LAT - 1);
            default: load_value = 4'(AND_LAT - 1);
        endcase
    endfunction

    for (genvar g = 0; g < N_BANKS; g++) begin : g_lane
        state_e      state_q, state_d;
        logic [3:0]  cnt_q, cnt_d;
        cmd_e        cmd_q, cmd_d;
        logic [31:0] op1_q, op1_d;
        logic [31:0] op2_q, op2_d;
        rsp_e        rsp_q, rsp_d;
        logic [31:0] data_q, data_d;

        cmd_e        in_cmd;
        logic [32:0] sum;
        logic [63:0] prod;

        assign in_cmd = cmd_e'(input_packet[g][65:64]);
        assign sum    = {1'b0, op1_q} + {1'b0, op2_q};
        assign prod   = {32'd0, op1_q} * {32'd0, op2_q};

        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            cmd_d   = cmd_q;
            op1_d   = op1_q;
            op2_d   = op2_q;
            rsp_d   = RSP_NONE;
            data_d  = data_q;

            case (state_q)
                ST_IDLE: begin
                    if (in_cmd != CMD_NOP) begin
                        cmd_d   = in_cmd;
                        op1_d   = input_packet[g][63:32];
                        op2_d   = input_packet[g][31:0];
                        cnt_d   = load_value(in_cmd);
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        case (cmd_q)
                            CMD_ADD: begin
                                data_d = sum[31:0];
                                rsp_d  = sum[32] ? RSP_OVERFLOW : RSP_SUCCESS;
                            end
                            CMD_MUL: begin
                                data_d = prod[31:0];
                                rsp_d  = (prod[63:32] != 32'd0) ? RSP_OVERFLOW : RSP_SUCCESS;
                            end
                            default: begin
                                data_d = op1_q & op2_q;
                                rsp_d  = RSP_SUCCESS;
                            end
                        endcase
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                // The single response cycle is over; inputs seen now are ignored.
                default: state_d = ST_IDLE;
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        always_ff @(posedge clock) begin
            if (!reset) begin
                // NOTE: the captured operand registers are reset as well; they
                // are only a handful of flops and this keeps X out of the
                // arithmetic and off the outputs straight after reset.
                state_q <= ST_IDLE;
                cnt_q   <= 4'd0;
                cmd_q   <= CMD_NOP;
                op1_q   <= 32'd0;
                op2_q   <= 32'd0;
                rsp_q   <= RSP_NONE;
                data_q  <= 32'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                cmd_q   <= cmd_d;
                op1_q   <= op1_d;
                op2_q   <= op2_d;
                rsp_q   <= rsp_d;
                data_q  <= data_d;
            end
        end

        assign output_packet[g] = {rsp_q, data_q};
        assign busy[g]          = (state_q == ST_BUSY);

`ifdef ALU_PERF_CNT_EN
        logic [15:0] op_cnt_q;
        logic [15:0] ovf_cnt_q;

        // Counters step on the same edge that drives the response, so they
        // already include a response while it is visible.
        always_ff @(posedge clock) begin
            if (!reset) begin
                op_cnt_q  <= 16'd0;
                ovf_cnt_q <= 16'd0;
            end else begin
                if (rsp_d != RSP_NONE && op_cnt_q != 16'hFFFF)
                    op_cnt_q <= op_cnt_q + 16'd1;
                if (rsp_d == RSP_OVERFLOW && ovf_cnt_q != 16'hFFFF)
                    ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end

        assign op_count[g]  = op_cnt_q;
        assign ovf_count[g] = ovf_cnt_q;
`endif
    end

endmodule

// File: tb/tb_alu_bank_responder.sv
`timescale 1ns / 1ps

module tb_alu_bank_responder;

    localparam int NB      = 4;
    localparam int ADD_LAT = 3;
    localparam int AND_LAT = 3;
    localparam int MUL_LAT = 5;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NB-1:0][65:0]   input_packet;
    logic [NB-1:0][33:0]   output_packet;
    logic [NB-1:0]         busy;
`ifdef ALU_PERF_CNT_EN
    logic [NB-1:0][15:0]   op_count;
    logic [NB-1:0][15:0]   ovf_count;
`endif

    alu_bank_responder #(
        .N_BANKS(NB), .ADD_LAT(ADD_LAT), .AND_LAT(AND_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .input_packet  (input_packet),
        .output_packet (output_packet),
        .busy          (busy)
`ifdef ALU_PERF_CNT_EN
        ,
        .op_count      (op_count),
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Stimulus held on each lane's inputs.
    logic [1:0]  cmd [NB];
    logic [31:0] a   [NB];
    logic [31:0] b   [NB];

    // Timeline reference model: each accepted request is remembered with the
    // edge at which its answer is due; a lane is free again two edges later.
    bit          pend      [NB];
    int          due       [NB];
    int          free_from [NB];
    logic [1:0]  eresp     [NB];
    logic [31:0] edata     [NB];
    logic [31:0] last      [NB];
    logic [1:0]  xresp     [NB];
    logic [31:0] xdata     [NB];
    bit          xbusy     [NB];
    int          opc       [NB];
    int          ovfc      [NB];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compute(input logic [1:0] c, input logic [31:0] x, input logic [31:0] y,
                           output logic [1:0] r, output logic [31:0] d);
        longint unsigned w;
        case (c)
            2'd1: begin
                w = x;
                w = w + y;
                d = w[31:0];
                r = (w > 64'hFFFF_FFFF) ? 2'd2 : 2'd1;
            end
            2'd2: begin
                w = x;
                w = w * y;
                d = w[31:0];
                r = (w > 64'hFFFF_FFFF) ? 2'd2 : 2'd1;
            end
            default: begin
                d = x & y;
                r = 2'd1;
            end
        endcase
    endtask

    task automatic model(input bit rst_v);
        for (int i = 0; i < NB; i++) begin
            if (!rst_v) begin
                pend[i] = 1'b0;
                last[i] = 32'd0;
                free_from[i] = cycle + 1;
                opc[i] = 0;
                ovfc[i] = 0;
                xresp[i] = 2'd0;
            end else begin
                xresp[i] = 2'd0;
                if (pend[i] && due[i] == cycle) begin
                    xresp[i] = eresp[i];
                    last[i]  = edata[i];
                    pend[i]  = 1'b0;
                    if (opc[i] < 16'hFFFF) opc[i]++;
                    if (eresp[i] == 2'd2 && ovfc[i] < 16'hFFFF) ovfc[i]++;
                end
                if (cycle >= free_from[i] && cmd[i] != 2'd0) begin
                    int lat;
                    lat = (cmd[i] == 2'd1) ? ADD_LAT : (cmd[i] == 2'd2) ? MUL_LAT : AND_LAT;
                    pend[i]      = 1'b1;
                    due[i]       = cycle + lat;
                    free_from[i] = due[i] + 2;
                    compute(cmd[i], a[i], b[i], eresp[i], edata[i]);
                end
            end
            xdata[i] = last[i];
            xbusy[i] = pend[i];
        end
    endtask

    // One clock edge: apply inputs, advance the model, compare every lane.
    task automatic step(input bit rst_v);
        reset = rst_v;
        for (int i = 0; i < NB; i++) input_packet[i] = {cmd[i], a[i], b[i]};
        @(posedge clock);
        cycle++;
        model(rst_v);
        #1;
        for (int i = 0; i < NB; i++) begin
            check($sformatf("resp[%0d]@%0d", i, cycle), 64'(output_packet[i][33:32]), 64'(xresp[i]));
            check($sformatf("data[%0d]@%0d", i, cycle), 64'(output_packet[i][31:0]), 64'(xdata[i]));
            check($sformatf("busy[%0d]@%0d", i, cycle), 64'(busy[i]), 64'(xbusy[i]));
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NB; i++) begin
            cmd[i] = 2'd0; a[i] = 32'd0; b[i] = 32'd0;
        end
    endtask

    task automatic issue(input int lane, input logic [1:0] c, input logic [31:0] x, input logic [31:0] y);
        cmd[lane] = c; a[lane] = x; b[lane] = y;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       rand_operand = 32'hFFFF_FFFF;
            1:       rand_operand = 32'($urandom_range(0, 100));
            2:       rand_operand = 32'h0001_0000 | 32'($urandom_range(0, 255));
            default: rand_operand = $urandom();
        endcase
    endfunction

    initial begin
        idle_all();
        for (int i = 0; i < NB; i++) begin
            pend[i] = 0; due[i] = 0; free_from[i] = 0; last[i] = 0;
            opc[i] = 0; ovfc[i] = 0;
        end

        // 1: reset for two edges, then release.
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("rst_data[%0d]", i), 64'(output_packet[i][31:0]), 64'h0);
            check($sformatf("rst_resp[%0d]", i), 64'(output_packet[i][33:32]), 64'h0);
            check($sformatf("rst_busy[%0d]", i), 64'(busy[i]), 64'h0);
        end
        step(1'b1);

        // 2: lane0 ADD overflow, exactly three edges after acceptance.
        issue(0, 2'd1, 32'hFFFF_FFFF, 32'h1);
        step(1'b1);
        idle_all();
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("s2_ovf_resp", 64'(output_packet[0][33:32]), 64'd2);
        check("s2_ovf_data", 64'(output_packet[0][31:0]), 64'd0);
        step(1'b1);
        check("s2_one_cycle", 64'(output_packet[0][33:32]), 64'd0);
        issue(0, 2'd1, 32'd2, 32'd3);
        step(1'b1);
        idle_all();
        for (int k = 0; k < 3; k++) step(1'b1);
        check("s2_add_resp", 64'(output_packet[0][33:32]), 64'd1);
        check("s2_add_data", 64'(output_packet[0][31:0]), 64'd5);
        step(1'b1);

        // 3: lane1 MULTIPLY overflow then 3*5.
        issue(1, 2'd2, 32'h0001_0000, 32'h0001_0000);
        step(1'b1);
        idle_all();
        for (int k = 0; k < 5; k++) step(1'b1);
        check("s3_ovf_resp", 64'(output_packet[1][33:32]), 64'd2);
        check("s3_ovf_data", 64'(output_packet[1][31:0]), 64'd0);
        step(1'b1);
        issue(1, 2'd2, 32'd3, 32'd5);
        step(1'b1);
        idle_all();
        for (int k = 0; k < 5; k++) step(1'b1);
        check("s3_mul_resp", 64'(output_packet[1][33:32]), 64'd1);
        check("s3_mul_data", 64'(output_packet[1][31:0]), 64'd15);
        step(1'b1);
`ifdef ALU_PERF_CNT_EN
        check("op_count0",  64'(op_count[0]),  64'd2);
        check("ovf_count0", 64'(ovf_count[0]), 64'd1);
        check("op_count1",  64'(op_count[1]),  64'd2);
        check("ovf_count1", 64'(ovf_count[1]), 64'd1);
`endif

        // 4: simultaneous AND on lane2 and MUL on lane3.
        issue(2, 2'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(3, 2'd2, 32'd7, 32'd6);
        step(1'b1);
        idle_all();
        for (int k = 0; k < 3; k++) step(1'b1);
        check("s4_and_resp", 64'(output_packet[2][33:32]), 64'd1);
        check("s4_and_data", 64'(output_packet[2][31:0]), 64'hF000_F000);
        check("s4_lane0_quiet", 64'(output_packet[0][33:32]), 64'd0);
        step(1'b1);
        step(1'b1);
        check("s4_mul_resp", 64'(output_packet[3][33:32]), 64'd1);
        check("s4_mul_data", 64'(output_packet[3][31:0]), 64'd42);
        step(1'b1);

        // 5: a second command while busy is ignored.
        issue(0, 2'd2, 32'd3, 32'd5);
        step(1'b1);
        issue(0, 2'd1, 32'd1, 32'd1);
        step(1'b1);
        idle_all();
        for (int k = 0; k < 4; k++) step(1'b1);
        check("s5_resp", 64'(output_packet[0][33:32]), 64'd1);
        check("s5_data", 64'(output_packet[0][31:0]), 64'd15);
        for (int k = 0; k < 4; k++) step(1'b1);

        // 6: reset mid-operation aborts without a response.
        issue(0, 2'd2, 32'd9, 32'd9);
        step(1'b1);
        idle_all();
        step(1'b1);
        step(1'b0);
        check("s6_busy", 64'(busy[0]), 64'd0);
        check("s6_data", 64'(output_packet[0][31:0]), 64'd0);
        for (int k = 0; k < 10; k++) step(1'b1);

        // Randomized traffic on all lanes against the model, with rare resets.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) cmd[i] = 2'd0;
                    else cmd[i] = 2'($urandom_range(1, 3));
                    a[i] = rand_operand();
                    b[i] = rand_operand();
                end
            end
            step($urandom_range(0, 199) != 0);
        end
        idle_all();
        for (int k = 0; k < 8; k++) step(1'b1);
`ifdef ALU_PERF_CNT_EN
        for (int i = 0; i < NB; i++) begin
            check($sformatf("rnd_op_count[%0d]", i), 64'(op_count[i]), 64'(opc[i]));
            check($sformatf("rnd_ovf_count[%0d]", i), 64'(ovf_count[i]), 64'(ovfc[i]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
